// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl
// Burst sequencer around a Fibonacci LFSR. A start request captures a seed
// and a word count. After one LOAD cycle the block streams exactly that many
// LFSR words downstream, honouring backpressure and abort. It finishes with a
// one-cycle done pulse. A zero seed is replaced by 1. Any all-zero LFSR update
// is forced back to 1, so the generator can never lock up.
//
// Output handshake: a word transfers on a rising clk edge where
// out_valid && out_ready. While out_valid is high, out_data holds stable
// until that transfer occurs. out_valid does not depend on out_ready.

module prbs_burst_ctrl #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter int               LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_sent,
  output logic             seed_fixed,
  output logic [1:0]       o_dbg_state
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Width-correct constant one for the LFSR and the counter
  localparam logic [WIDTH-1:0] LFSR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  // Registers
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seed_eff;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_words;
  logic             r_seed_fixed;

  // Combinational helpers
  logic [1:0]       w_state_nxt;
  logic             w_fb;
  logic [WIDTH-1:0] w_lfsr_shift;
  logic [WIDTH-1:0] w_lfsr_step;
  logic             w_seed_zero;
  logic [LEN_W-1:0] w_words_inc;
  logic             w_last;
  logic             w_hs;
  logic             w_run;

  assign w_run       = (r_state == ST_RUN);
  assign w_hs        = w_run & out_ready;
  assign w_fb        = ^(r_lfsr & TAPS);
  assign w_lfsr_shift = {r_lfsr[WIDTH-2:0], w_fb};
  // A non-maximal tap mask could shift into all zeros; substitute 1 instead.
  assign w_lfsr_step = (w_lfsr_shift == '0) ? LFSR_ONE : w_lfsr_shift;
  assign w_seed_zero = (seed == '0);
  // Counter never reaches the captured length before the burst ends, so +1 cannot wrap.
  assign w_words_inc = r_words + LEN_ONE;
  assign w_last      = (w_words_inc == r_len);

  // Next-state decision for the burst sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort || (r_len == '0)) w_state_nxt = ST_DONE;
        else                        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // An abort still lets a same-cycle handshake complete (handled below).
        if (abort || (w_hs && w_last)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Capture length and effective seed when a request is accepted in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len        <= '0;
      r_seed_eff   <= LFSR_ONE;
      r_seed_fixed <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_len        <= burst_len;
      r_seed_eff   <= w_seed_zero ? LFSR_ONE : seed;
      r_seed_fixed <= w_seed_zero;
    end
  end

  // LFSR: seeded in LOAD, advanced once per completed handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= LFSR_ONE;
    end else if (r_state == ST_LOAD) begin
      r_lfsr <= r_seed_eff;
    end else if (w_hs) begin
      r_lfsr <= w_lfsr_step;
    end
  end

  // Handshake counter: cleared in LOAD, held through DONE/IDLE for readback
  always_ff @(posedge clk) begin
    if (reset) begin
      r_words <= '0;
    end else if (r_state == ST_LOAD) begin
      r_words <= '0;
    end else if (w_hs) begin
      r_words <= w_words_inc;
    end
  end

  // Outputs are decoded straight from registers (no input-to-output paths)
  assign out_valid   = w_run;
  assign out_data    = r_lfsr;
  assign busy        = (r_state == ST_LOAD) || w_run;
  assign done        = (r_state == ST_DONE);
  assign words_sent  = r_words;
  assign seed_fixed  = r_seed_fixed;
  assign o_dbg_state = r_state;

endmodule
